// File: rtl/rle_word_arbiter.sv
// Round-robin merge of per-channel RLE coder words into one
// valid/ready output stream, with per-channel drop flags and a sent count.
module rle_word_arbiter #(
  parameter int N     = 16,
  parameter int CH    = 8,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            en,
  input  logic [CH*N-1:0] word_in,
  input  logic [CH-1:0]   ready_in,
  output logic [N-1:0]    out_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH-1:0]   ovf,
  input  logic            clr_ovf,
  output logic [CNT_W-1:0] words_sent
);

  localparam int PW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0] rdy_d;
  logic [CH-1:0] pend;
  logic [CH-1:0] nw;
  logic [CH-1:0] gnt_vec;
  logic [CH-1:0] set_ovf;
  logic [N-1:0]  hold [CH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx;
  logic          found;
  logic          free;
  logic          grant;

  assign free  = ~out_valid | out_ready;
  assign nw    = ready_in & ~rdy_d & {CH{en}};
  assign grant = en & free & found;

  // Search starts one past the last granted channel.
  always_comb begin
    found = 1'b0;
    gidx  = ptr;
    idx   = '0;
    for (int k = 1; k <= CH; k++) begin
      idx = PW'((int'(ptr) + k) % CH);
      if (!found && pend[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  always_comb begin
    gnt_vec = '0;
    if (grant) gnt_vec[gidx] = 1'b1;
    set_ovf = nw & pend & ~gnt_vec;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      rdy_d      <= '0;
      pend       <= '0;
      ovf        <= '0;
      ptr        <= PW'(CH - 1);
      out_word   <= '0;
      out_valid  <= 1'b0;
      words_sent <= '0;
      for (int i = 0; i < CH; i++) hold[i] <= '0;
    end else begin
      if (en) rdy_d <= ready_in;
      for (int i = 0; i < CH; i++) begin
        if (nw[i] && (!pend[i] || gnt_vec[i])) begin
          hold[i] <= word_in[i*N +: N];
          pend[i] <= 1'b1;
        end else if (gnt_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
      ovf <= set_ovf | (clr_ovf ? '0 : ovf);
      if (grant) begin
        out_word  <= hold[gidx];
        out_valid <= 1'b1;
        ptr       <= gidx;
      end else if (free) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready)
        words_sent <= words_sent + 1'b1;
    end
  end

endmodule

// File: tb/tb_rle_word_arbiter.sv
// Self-checking bench for rle_word_arbiter: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_rle_word_arbiter;

  localparam int N     = 16;
  localparam int CH    = 8;
  localparam int CNT_W = 16;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic            en = 1'b1;
  logic [CH*N-1:0] word_in = '0;
  logic [CH-1:0]   ready_in = '0;
  logic [N-1:0]    out_word;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CH-1:0]   ovf;
  logic            clr_ovf = 1'b0;
  logic [CNT_W-1:0] words_sent;

  int n_vec = 0;
  int n_err = 0;

  rle_word_arbiter #(.N(N), .CH(CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .nreset(nreset), .en(en),
    .word_in(word_in), .ready_in(ready_in),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .ovf(ovf), .clr_ovf(clr_ovf), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [N-1:0]     m_word = '0;
  logic             m_valid = 1'b0;
  logic [CH-1:0]    m_ovf = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic [CH-1:0]    m_rdy = '0;
  bit               m_pend [CH];
  logic [N-1:0]     m_hold [CH];
  int               m_last = CH - 1;

  task automatic model_step();
    logic [CH-1:0] setb;
    int g;
    bit fr;
    if (!nreset) begin
      m_word = '0; m_valid = 0; m_ovf = '0; m_cnt = '0;
      m_rdy = '0; m_last = CH - 1;
      for (int i = 0; i < CH; i++) begin
        m_pend[i] = 0; m_hold[i] = '0;
      end
      return;
    end
    fr = !m_valid || out_ready;
    if (m_valid && out_ready) m_cnt = m_cnt + 1'b1;
    g = -1;
    if (en && fr)
      for (int k = 1; k <= CH; k++)
        if (g < 0 && m_pend[(m_last + k) % CH]) g = (m_last + k) % CH;
    if (g >= 0) begin
      m_word = m_hold[g]; m_valid = 1; m_last = g;
    end else if (fr) begin
      m_valid = 0;
    end
    setb = '0;
    for (int i = 0; i < CH; i++) begin
      if (en && ready_in[i] && !m_rdy[i]) begin
        if (m_pend[i] && i != g) setb[i] = 1'b1;
        else begin
          m_hold[i] = word_in[i*N +: N];
          m_pend[i] = 1;
        end
      end else if (i == g) begin
        m_pend[i] = 0;
      end
    end
    m_ovf = (clr_ovf ? '0 : m_ovf) | setb;
    if (en) m_rdy = ready_in;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset = 0; ready_in = '0; out_ready = 0; en = 1; clr_ovf = 0;
    tick(); tick();
    nreset = 1;
  endtask

  task automatic set_word(input int ch, input logic [N-1:0] w);
    word_in[ch*N +: N] = w;
  endtask

  task automatic test_reset();
    nreset = 0; ready_in = 8'hFF; out_ready = 1; en = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if ({out_valid, out_word, ovf, words_sent} !== '0) begin
        n_err++;
        $display("FAIL reset_state: valid=%b word=%h ovf=%h sent=%0d want all 0",
                 out_valid, out_word, ovf, words_sent);
      end
    end
    ready_in = '0;
    nreset = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle: out_valid=%b want 0", out_valid);
      end
    end
  endtask

  task automatic test_single();
    out_ready = 1;
    set_word(3, 16'h9A5C);
    ready_in = 8'h08;
    tick();
    ready_in = '0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_lat1: out_valid=%b want 0", out_valid);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_word !== 16'h9A5C) begin
      n_err++;
      $display("FAIL single_out: valid=%b word=%h want 1/9a5c", out_valid, out_word);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || words_sent !== 16'd1) begin
      n_err++;
      $display("FAIL single_done: valid=%b sent=%0d want 0/1", out_valid, words_sent);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp1 [3];
    logic [N-1:0] exp2 [2];
    exp1[0] = 16'h8001; exp1[1] = 16'h8002; exp1[2] = 16'h8005;
    exp2[0] = 16'h8001; exp2[1] = 16'h8005;
    do_reset();
    out_ready = 1;
    set_word(0, 16'h8001); set_word(2, 16'h8002); set_word(5, 16'h8005);
    ready_in = 8'h25;
    tick();
    ready_in = '0;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_word !== exp1[j]) begin
        n_err++;
        $display("FAIL rr_first[%0d]: valid=%b word=%h want 1/%h",
                 j, out_valid, out_word, exp1[j]);
      end
    end
    ready_in = 8'h21;
    tick();
    ready_in = '0;
    for (int j = 0; j < 2; j++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_word !== exp2[j]) begin
        n_err++;
        $display("FAIL rr_wrap[%0d]: valid=%b word=%h want 1/%h",
                 j, out_valid, out_word, exp2[j]);
      end
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || words_sent !== 16'd5) begin
      n_err++;
      $display("FAIL rr_end: valid=%b sent=%0d want 0/5", out_valid, words_sent);
    end
  endtask

  task automatic test_overflow();
    out_ready = 0;
    set_word(0, 16'h0F0F); ready_in = 8'h01; tick();
    ready_in = '0; tick();
    set_word(1, 16'h1111); ready_in = 8'h02; tick();
    ready_in = '0; tick();
    set_word(1, 16'h2222); ready_in = 8'h02; tick();
    n_vec++;
    if (ovf !== 8'h02) begin
      n_err++;
      $display("FAIL ovf_set: ovf=%h want 02", ovf);
    end
    ready_in = '0; out_ready = 1;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_word !== 16'h1111) begin
      n_err++;
      $display("FAIL ovf_kept: valid=%b word=%h want 1/1111", out_valid, out_word);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || ovf !== 8'h02) begin
      n_err++;
      $display("FAIL ovf_drop: valid=%b ovf=%h want 0/02", out_valid, ovf);
    end
    clr_ovf = 1; tick(); clr_ovf = 0;
    n_vec++;
    if (ovf !== 8'h00) begin
      n_err++;
      $display("FAIL ovf_clr: ovf=%h want 00", ovf);
    end
  endtask

  task automatic test_collision();
    out_ready = 0;
    set_word(0, 16'h0A0A); ready_in = 8'h01; tick();
    ready_in = '0; tick();
    set_word(4, 16'h4444); ready_in = 8'h10; tick();
    ready_in = '0; tick();
    set_word(4, 16'h4545); ready_in = 8'h10; out_ready = 1;
    tick();
    ready_in = '0;
    n_vec++;
    if (out_valid !== 1'b1 || out_word !== 16'h4444) begin
      n_err++;
      $display("FAIL coll_old: valid=%b word=%h want 1/4444", out_valid, out_word);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_word !== 16'h4545 || ovf[4] !== 1'b0) begin
      n_err++;
      $display("FAIL coll_new: valid=%b word=%h ovf4=%b want 1/4545/0",
               out_valid, out_word, ovf[4]);
    end
    tick();
  endtask

  task automatic test_enable();
    logic [CNT_W-1:0] base;
    out_ready = 0;
    set_word(2, 16'h2C2C); ready_in = 8'h04; tick();
    ready_in = '0; tick();
    base = m_cnt;
    en = 0; out_ready = 1;
    set_word(6, 16'h6666); ready_in = 8'h40;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) ready_in = '0;
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || words_sent !== base + 1'b1) begin
        n_err++;
        $display("FAIL en_off[%0d]: valid=%b sent=%0d want 0/%0d",
                 c, out_valid, words_sent, base + 1'b1);
      end
    end
    en = 1; tick();
    set_word(6, 16'h6767); ready_in = 8'h40; tick();
    ready_in = '0; tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_word !== 16'h6767) begin
      n_err++;
      $display("FAIL en_on: valid=%b word=%h want 1/6767", out_valid, out_word);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < CH; i++) set_word(i, 16'hB000 + 16'(i));
    ready_in = '1;
    tick();
    ready_in = '0;
    for (int i = 0; i < CH; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_word !== 16'hB000 + 16'(i)) begin
        n_err++;
        $display("FAIL b2b[%0d]: valid=%b word=%h want 1/%h",
                 i, out_valid, out_word, 16'hB000 + 16'(i));
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      nreset    = ($urandom % 200) != 0;
      en        = ($urandom % 8) != 0;
      ready_in  = CH'($urandom);
      word_in   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom % 4) != 0;
      clr_ovf   = ($urandom % 16) == 0;
      tick();
      n_vec++;
      if (out_valid !== m_valid || out_word !== m_word ||
          ovf !== m_ovf || words_sent !== m_cnt) begin
        n_err++;
        $display("FAIL rand[%0d]: v=%b w=%h o=%h n=%0d want v=%b w=%h o=%h n=%0d",
                 c, out_valid, out_word, ovf, words_sent,
                 m_valid, m_word, m_ovf, m_cnt);
      end
    end
    nreset = 1; clr_ovf = 0; en = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_collision();
    test_enable();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rle_word_arbiter.md
# rle_word_arbiter

Collects the compressed 16-bit words produced by the per-channel RLE coders of the logic analyzer and merges them into one output stream for the capture FIFO/transmit path. Each channel has a one-entry holding register. Pending words are granted round-robin into a single output register with a valid/ready handshake. Per-channel overflow flags and a sent-word counter give the host visibility of dropped data.

## Interface
- N, 16, word width; matches coder word_out width
- CH, 8, number of coder channels (2..16)
- CNT_W, 16, width of sent-word counter
- clk  in  1  system clock; all logic on posedge
- nreset  in  1  synchronous active-low reset
- en  in  1  global enable; when 0 the block freezes (see Operation)
- word_in  in  CH*N  channel i word at bits [i*N +: N]
- ready_in  in  CH  per-channel word-ready level from coder; a rising edge marks a new word
- out_word  out  N  granted word
- out_valid  out  1  out_word holds an unconsumed word
- out_ready  in  1  consumer accepts out_word on a cycle where out_valid=1
- ovf  out  CH  sticky per-channel overflow (word dropped)
- clr_ovf  in  1  clears ovf
- words_sent  out  CNT_W  count of accepted output words, wraps modulo 2^CNT_W

## Operation
- Edge detect: rdy_d[i] registers ready_in[i]. new[i] = ready_in[i] & ~rdy_d[i] & en. rdy_d updates only when en=1.
- Capture: if new[i], word_in[i] is loaded into hold[i] and pend[i] is set to 1.
  - Exception: if pend[i]=1 and channel i is not granted in the same cycle, the new word is dropped. hold[i] keeps the old word and ovf[i] is set.
  - If new[i] occurs while channel i is being granted in the same cycle, the old word goes out, the new word is captured, and ovf is not set.
- Output slot free: free = ~out_valid | out_ready.
- Grant: when en=1, free=1 and any pend=1, select the first pending index found by searching ptr+1, ptr+2, … modulo CH.
  - out_word is loaded with hold[g], out_valid is set to 1, pend[g] is cleared, and ptr is set to g.
- If free=1 and no pend bit is set, out_valid goes to 0 on the next edge. If out_ready=0, out_valid and out_word hold.
- words_sent increments on every edge where out_valid & out_ready, regardless of en.
- clr_ovf clears all ovf bits. A set in the same cycle wins over clr_ovf.
- With en=0: no capture, no grant, pend/hold/ptr frozen. The output handshake still completes (out_valid drops if accepted).
- Reset values: out_word=0, out_valid=0, ovf=0, words_sent=0, pend=0, hold=0, rdy_d=0, ptr=CH-1 (so the first search starts at channel 0).
- Reset has priority over all other activity and aborts any transfer in progress. A word held in out_word at reset is discarded and not counted.

## Timing
- Rising ready_in seen at edge t: pend set after edge t. If the slot is free, out_valid=1 after edge t+1. Minimum latency is 2 cycles.
- Throughput: one word per cycle when out_ready is held high.
- Fairness: with all CH channels continuously pending, each channel is granted exactly once every CH grants.
- ready_in must stay low at least 1 cycle between words to produce a new edge. A level held high produces only one capture.
- word_in[i] must be stable on the edge where the rising ready_in[i] is sampled.

## Test plan
- Reset with ready_in=0xFF held: all outputs at reset values. After nreset=1, no capture occurs because there is no rising edge.
- Single channel: pulse ready_in[3] with word_in[3]=0x9A5C and out_ready=1. Then out_valid=1 exactly 2 cycles later, out_word=0x9A5C for 1 cycle, and words_sent=1.
- Round-robin: channels 0, 2 and 5 rise on the same cycle with words 0x8001/0x8002/0x8005 and out_ready=1. Output order is 0x8001, 0x8002, 0x8005 on consecutive cycles. Next, channels 0 and 5 rise together; output order is 0x8001 then 0x8005 (search starts after 5, wraps to 0).
- Backpressure/overflow: out_ready=0. Channel 1 sends 0x1111, then channel 1 sends 0x2222 while still pending and not granted. Result: ovf[1]=1, 0x2222 dropped. Release out_ready; only 0x1111 appears. Pulse clr_ovf and ovf returns to 0.
- Grant-and-capture collision: channel 4 is pending with 0x4444 and is granted on the same cycle its next edge arrives with 0x4545. Output is 0x4444 then 0x4545, with ovf[4]=0.
- en=0 for 10 cycles with an edge on ready_in[6]: no capture and out_valid stays 0. The pending output word is still accepted and words_sent increments. After en=1, a fresh edge on ready_in[6] is captured normally.
